cordic_range_reducer: RTL and testbench

//  Angle range-reduction stage ahead of the CORDIC core. Takes an IEEE-754 angle in [-pi, pi],

---
 rtl/cordic_range_reducer_if.sv | 31 +++
 rtl/cordic_range_reducer.sv | 157 +++++++++++++++
 tb/tb_cordic_range_reducer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_range_reducer_if.sv
// Request/acknowledge bus between the range reducer and the shared FP add/sub unit.
// The reducer is the master: it raises a one-cycle add_req with operands A - B and
// waits for a one-cycle add_ack carrying the result.
interface cordic_range_reducer_if #(
  parameter int W = 32
);
  logic         add_req;
  logic         add_subt;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_ack;
  logic [W-1:0] add_result;

  modport master (
    output add_req,
    output add_subt,
    output add_a,
    output add_b,
    input  add_ack,
    input  add_result
  );

  modport slave (
    input  add_req,
    input  add_subt,
    input  add_a,
    input  add_b,
    output add_ack,
    output add_result
  );
endinterface

// File: rtl/cordic_range_reducer.sv
// Angle range reduction ahead of the CORDIC core. An IEEE-754 angle in [-pi, pi] is
// folded into [-pi/2, pi/2]: angles beyond +/-pi/2 are replaced by (+/-pi - theta),
// computed on the shared FP adder, and tagged with shift_region_flag = 01 so the
// sign-inversion stage negates the cosine. NaN, infinities and |theta| > pi are
// passed through raw with invalid set. Only W = 32 and W = 64 are meaningful.
module cordic_range_reducer #(
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   beg_reduc,
  input  logic [W-1:0]           data_in,
  output logic                   busy,
  output logic [W-1:0]           data_out,
  output logic [1:0]             shift_region_flag,
  output logic                   invalid,
  output logic                   ready_reduc,
  cordic_range_reducer_if.master add_bus
);

  // Exponent field width and the pi / pi/2 bit patterns for the selected precision.
  localparam int          EXP_W    = (W == 64) ? 11 : 8;
  localparam logic [63:0] PI_SEL   = (W == 64) ? 64'h4009_21FB_5444_2D18 : 64'h0000_0000_4049_0FDB;
  localparam logic [63:0] PIH_SEL  = (W == 64) ? 64'h3FF9_21FB_5444_2D18 : 64'h0000_0000_3FC9_0FDB;
  localparam logic [W-1:0] PI_C    = PI_SEL[W-1:0];
  localparam logic [W-2:0] PI_MAG  = PI_SEL[W-2:0];
  localparam logic [W-2:0] PIH_MAG = PIH_SEL[W-2:0];

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t         state_r;
  logic [W-1:0]   angle_r;
  logic [W-1:0]   data_out_r;
  logic [1:0]     flag_r;
  logic           invalid_r;
  logic           ready_r;
  logic           busy_r;
  logic           add_req_r;
  logic           add_subt_r;
  logic [W-1:0]   add_a_r;
  logic [W-1:0]   add_b_r;

  logic [W-2:0]   mag_s;
  logic [EXP_W-1:0] exp_s;
  logic           special_s;
  logic           over_pi_s;
  logic           no_fold_s;

  // Classify the captured angle by its magnitude bits; for positive IEEE values the
  // unsigned integer order of the bit pattern equals the numeric order.
  always_comb begin
    mag_s     = angle_r[W-2:0];
    exp_s     = angle_r[W-2 -: EXP_W];
    special_s = &exp_s;
    over_pi_s = (mag_s > PI_MAG);
    no_fold_s = (mag_s <= PIH_MAG);
  end

  // Control FSM; every output is a register updated on the transition into the state
  // in which it must be visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      angle_r    <= {W{1'b0}};
      data_out_r <= {W{1'b0}};
      flag_r     <= 2'b00;
      invalid_r  <= 1'b0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      add_req_r  <= 1'b0;
      add_subt_r <= 1'b0;
      add_a_r    <= {W{1'b0}};
      add_b_r    <= {W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_r <= 1'b0;
          if (beg_reduc) begin
            angle_r <= data_in;
            busy_r  <= 1'b1;
            state_r <= ST_CHECK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (special_s || over_pi_s) begin
            invalid_r  <= 1'b1;
            data_out_r <= angle_r;
            flag_r     <= 2'b00;
            ready_r    <= 1'b1;
            state_r    <= ST_DONE;
          end else if (no_fold_s) begin
            invalid_r  <= 1'b0;
            data_out_r <= angle_r;
            flag_r     <= 2'b00;
            ready_r    <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            // Minuend carries the angle's sign so the result is +pi - theta or -pi - theta.
            invalid_r  <= 1'b0;
            flag_r     <= 2'b01;
            add_a_r    <= {angle_r[W-1], PI_C[W-2:0]};
            add_b_r    <= angle_r;
            add_subt_r <= 1'b1;
            add_req_r  <= 1'b1;
            state_r    <= ST_REQ;
          end
        end
        ST_REQ: begin
          add_req_r <= 1'b0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (add_bus.add_ack) begin
            data_out_r <= add_bus.add_result;
            add_subt_r <= 1'b0;
            add_a_r    <= {W{1'b0}};
            add_b_r    <= {W{1'b0}};
            ready_r    <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r   <= 1'b0;
          busy_r    <= 1'b0;
          add_req_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy              = busy_r;
  assign data_out          = data_out_r;
  assign shift_region_flag = flag_r;
  assign invalid           = invalid_r;
  assign ready_reduc       = ready_r;
  assign add_bus.add_req   = add_req_r;
  assign add_bus.add_subt  = add_subt_r;
  assign add_bus.add_a     = add_a_r;
  assign add_bus.add_b     = add_b_r;

endmodule

// File: tb/tb_cordic_range_reducer.sv
// Bench for cordic_range_reducer (single precision): directed vector table, randomized
// angles against a rule-level reference model, and an abort-by-reset sequence.
module tb_cordic_range_reducer;

  localparam int W = 32;
  localparam logic [31:0] PI_BITS  = 32'h4049_0FDB;
  localparam logic [31:0] PIH_BITS = 32'h3FC9_0FDB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         beg_reduc = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         busy;
  logic [W-1:0] data_out;
  logic [1:0]   shift_region_flag;
  logic         invalid;
  logic         ready_reduc;

  cordic_range_reducer_if #(.W(W)) add_bus ();

  cordic_range_reducer #(.W(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .beg_reduc         (beg_reduc),
    .data_in           (data_in),
    .busy              (busy),
    .data_out          (data_out),
    .shift_region_flag (shift_region_flag),
    .invalid           (invalid),
    .ready_reduc       (ready_reduc),
    .add_bus           (add_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] d;
    int          dly;
    logic [31:0] ackv;
    logic [31:0] exp_out;
    logic [1:0]  exp_flag;
    logic        exp_inv;
    logic [31:0] exp_a;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model from the folding rules: special/too large -> invalid, |theta| <= pi/2
  // -> pass through, otherwise fold with +/-pi as minuend and take the adder's answer.
  task automatic ref_model(input logic [31:0] d, input logic [31:0] ackv,
                           output logic [31:0] eo, output logic [1:0] ef,
                           output logic ei, output logic [31:0] ea);
    logic [30:0] mag;
    logic        non_finite;
    mag        = d[30:0];
    non_finite = (d[30:23] == 8'hFF);
    ea         = d[31] ? (PI_BITS | 32'h8000_0000) : PI_BITS;
    if (non_finite || mag > PI_BITS[30:0]) begin
      ei = 1'b1; ef = 2'b00; eo = d;
    end else if (mag <= PIH_BITS[30:0]) begin
      ei = 1'b0; ef = 2'b00; eo = d;
    end else begin
      ei = 1'b0; ef = 2'b01; eo = ackv;
    end
  endtask

  // One full transaction with an acking adder model; noise adds a start while busy
  // and a stray ack during CHECK, both of which must be ignored.
  task automatic run_one(input vec_t v, input bit noise);
    int done_at, req_cnt, req_at, exp_lat;
    bit fold;
    fold    = (v.exp_flag == 2'b01);
    exp_lat = fold ? 3 + v.dly : 2;
    done_at = -1; req_cnt = 0; req_at = -100;
    @(negedge clk);
    data_in = v.d; beg_reduc = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      beg_reduc = noise && (i == 2);
      if (i == 1) data_in = $urandom;
      chk("busy_while_active", busy, 1'b1);
      if (add_bus.add_req) begin
        req_cnt++; req_at = i;
        chk("add_a", add_bus.add_a, v.exp_a);
        chk("add_b", add_bus.add_b, v.d);
        chk("add_subt", add_bus.add_subt, 1'b1);
      end
      add_bus.add_ack    = (req_cnt > 0 && i == req_at + v.dly) || (noise && i == 1);
      add_bus.add_result = (req_cnt > 0 && i == req_at + v.dly) ? v.ackv : $urandom;
      if (ready_reduc) begin
        done_at = i;
        break;
      end
    end
    beg_reduc = 1'b0; add_bus.add_ack = 1'b0;
    chk("latency", done_at, exp_lat);
    chk("req_count", req_cnt, fold ? 1 : 0);
    chk("data_out", data_out, v.exp_out);
    chk("flag", shift_region_flag, v.exp_flag);
    chk("invalid", invalid, v.exp_inv);
    @(negedge clk);
    chk("ready_single_pulse", ready_reduc, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
    chk("data_out_hold", data_out, v.exp_out);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [31:0] d;
    int k, ready_seen;
    add_bus.add_ack = 1'b0;
    add_bus.add_result = '0;

    // Reset values while rst is held low.
    #3;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_flag", shift_region_flag, 2'b00);
    chk("rst_invalid", invalid, 1'b0);
    chk("rst_ready", ready_reduc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_add_req", add_bus.add_req, 1'b0);
    chk("rst_add_subt", add_bus.add_subt, 1'b0);
    chk("rst_add_a", add_bus.add_a, 32'h0);
    chk("rst_add_b", add_bus.add_b, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    //           d             dly ackv          exp_out       flag   inv   exp_a
    tbl.push_back('{32'h3F80_0000, 2, 32'h1111_1111, 32'h3F80_0000, 2'b00, 1'b0, 32'h4049_0FDB});
    tbl.push_back('{32'h4000_0000, 3, 32'h3F92_1FB6, 32'h3F92_1FB6, 2'b01, 1'b0, 32'h4049_0FDB});
    tbl.push_back('{32'hC000_0000, 1, 32'hC000_0000, 32'hC000_0000, 2'b01, 1'b0, 32'hC049_0FDB});
    tbl.push_back('{32'h3FC9_0FDB, 2, 32'h2222_2222, 32'h3FC9_0FDB, 2'b00, 1'b0, 32'h4049_0FDB});
    tbl.push_back('{32'hBFC9_0FDB, 2, 32'h2222_2222, 32'hBFC9_0FDB, 2'b00, 1'b0, 32'hC049_0FDB});
    tbl.push_back('{32'h4049_0FDB, 2, 32'h3F00_0000, 32'h3F00_0000, 2'b01, 1'b0, 32'h4049_0FDB});
    tbl.push_back('{32'hC049_0FDB, 4, 32'h8000_0000, 32'h8000_0000, 2'b01, 1'b0, 32'hC049_0FDB});
    tbl.push_back('{32'h3FC9_0FDC, 5, 32'h3FC9_0FDA, 32'h3FC9_0FDA, 2'b01, 1'b0, 32'h4049_0FDB});
    tbl.push_back('{32'h7FC0_0000, 1, 32'h3333_3333, 32'h7FC0_0000, 2'b00, 1'b1, 32'h4049_0FDB});
    tbl.push_back('{32'h7F80_0000, 1, 32'h3333_3333, 32'h7F80_0000, 2'b00, 1'b1, 32'h4049_0FDB});
    tbl.push_back('{32'hFF80_0000, 1, 32'h3333_3333, 32'hFF80_0000, 2'b00, 1'b1, 32'hC049_0FDB});
    tbl.push_back('{32'h4050_0000, 1, 32'h3333_3333, 32'h4050_0000, 2'b00, 1'b1, 32'h4049_0FDB});
    tbl.push_back('{32'h4049_0FDC, 1, 32'h3333_3333, 32'h4049_0FDC, 2'b00, 1'b1, 32'h4049_0FDB});
    tbl.push_back('{32'h0000_0000, 1, 32'h4444_4444, 32'h0000_0000, 2'b00, 1'b0, 32'h4049_0FDB});
    tbl.push_back('{32'h8000_0001, 1, 32'h4444_4444, 32'h8000_0001, 2'b00, 1'b0, 32'hC049_0FDB});

    foreach (tbl[i]) run_one(tbl[i], (i % 2) == 1);

    // Randomized angles biased toward each region, checked against the rule-level model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = {1'b0, 31'($urandom_range(0, int'(PIH_BITS)))};
        2:       d = {1'b0, 31'($urandom_range(int'(PIH_BITS) + 1, int'(PI_BITS)))};
        default: d = {1'b0, 31'($urandom_range(int'(PI_BITS) + 1, 32'h7FFF_FFFF))};
      endcase
      d[31]  = 1'($urandom_range(0, 1));
      v.d    = d;
      v.dly  = $urandom_range(1, 6);
      v.ackv = $urandom;
      ref_model(v.d, v.ackv, v.exp_out, v.exp_flag, v.exp_inv, v.exp_a);
      run_one(v, 1'($urandom_range(0, 1)));
    end

    // Reset while waiting on the adder; a late ack must not produce a result.
    @(negedge clk);
    data_in = 32'h4000_0000; beg_reduc = 1'b1;
    @(negedge clk);
    beg_reduc = 1'b0;
    k = 0;
    while (!add_bus.add_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("abort_req_seen", add_bus.add_req, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_in_wait", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_data_out", data_out, 32'h0);
    chk("abort_flag", shift_region_flag, 2'b00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_add_a", add_bus.add_a, 32'h0);
    chk("abort_add_subt", add_bus.add_subt, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    add_bus.add_ack = 1'b1; add_bus.add_result = 32'h3F00_0000;
    ready_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      add_bus.add_ack = 1'b0;
      if (ready_reduc) ready_seen++;
    end
    chk("abort_no_ready", ready_seen, 0);
    chk("abort_data_out_after_ack", data_out, 32'h0);
    chk("abort_idle", busy, 1'b0);
    chk("abort_no_req", add_bus.add_req, 1'b0);

    // Normal operation resumes after the abort.
    v = '{32'hC000_0000, 2, 32'hBF92_1FB6, 32'hBF92_1FB6, 2'b01, 1'b0, 32'hC049_0FDB};
    run_one(v, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
